// File: rtl/cga_mic_outcount_if.sv
// Bus bundle between the control-store readback block and its data-bus / consumer side.
// The master side drives the request and control-store inputs; the slave side is the block.
interface cga_mic_outcount_if;
    logic [1:0]  CD;
    logic        LRCAN;
    logic        RSTRT;
    logic        RACK;
    logic [63:0] CSD;
    logic [1:0]  CSRAN;
    logic        RBSY;
    logic        RVAL;
    logic [15:0] RDAT;
    logic        RDONE;

    modport master (
        output CD, LRCAN, RSTRT, RACK, CSD,
        input  CSRAN, RBSY, RVAL, RDAT, RDONE
    );

    modport slave (
        input  CD, LRCAN, RSTRT, RACK, CSD,
        output CSRAN, RBSY, RVAL, RDAT, RDONE
    );
endinterface

// File: rtl/cga_mic_outcount.sv
// Microword readback: latches one 64-bit control-store word and streams it out as
// 16-bit words from a loadable start index up to word 3, with ready/valid backpressure.
module cga_mic_outcount (
    input  logic                  MCLK,
    input  logic                  MRN,
    cga_mic_outcount_if.slave     bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LATCH = 2'b01,
        ST_SEND  = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    state_t      state_r;
    logic [1:0]  cnt_r;
    logic [63:0] hold_r;
    logic        rbsy_r;
    logic        rval_r;
    logic [15:0] rdat_r;
    logic        rdone_r;

    logic [1:0]  load_cnt_s;
    logic [1:0]  cnt_inc_s;

    function automatic logic [15:0] sel_word(input logic [63:0] word, input logic [1:0] idx);
        case (idx)
            2'd0:    return word[15:0];
            2'd1:    return word[31:16];
            2'd2:    return word[47:32];
            2'd3:    return word[63:48];
            default: return 16'h0000;
        endcase
    endfunction

    // Counter value for an IDLE cycle (load from CD on LRCAN low) and the SEND increment.
    always_comb begin
        load_cnt_s = cnt_r;
        cnt_inc_s  = cnt_r + 2'd1;
        if (!bus.LRCAN) begin
            load_cnt_s = bus.CD;
        end else begin
            load_cnt_s = cnt_r;
        end
    end

    // Readback FSM with counter, holding register and registered outputs.
    always_ff @(posedge MCLK or negedge MRN) begin
        if (!MRN) begin
            state_r <= ST_IDLE;
            cnt_r   <= 2'd0;
            hold_r  <= 64'd0;
            rbsy_r  <= 1'b0;
            rval_r  <= 1'b0;
            rdat_r  <= 16'h0000;
            rdone_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    cnt_r   <= load_cnt_s;
                    rval_r  <= 1'b0;
                    rdat_r  <= 16'h0000;
                    rdone_r <= 1'b0;
                    if (bus.RSTRT) begin
                        state_r <= ST_LATCH;
                        rbsy_r  <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        rbsy_r  <= 1'b0;
                    end
                end
                ST_LATCH: begin
                    // The presented word comes straight from CSD here so it lines up with HOLD.
                    hold_r  <= bus.CSD;
                    rdat_r  <= sel_word(bus.CSD, cnt_r);
                    rval_r  <= 1'b1;
                    state_r <= ST_SEND;
                end
                ST_SEND: begin
                    if (bus.RACK) begin
                        if (cnt_r == 2'd3) begin
                            cnt_r   <= 2'd0;
                            rval_r  <= 1'b0;
                            rdat_r  <= 16'h0000;
                            rdone_r <= 1'b1;
                            state_r <= ST_DONE;
                        end else begin
                            cnt_r  <= cnt_inc_s;
                            rdat_r <= sel_word(hold_r, cnt_inc_s);
                        end
                    end else begin
                        cnt_r  <= cnt_r;
                        rdat_r <= rdat_r;
                    end
                end
                ST_DONE: begin
                    rdone_r <= 1'b0;
                    rbsy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= 2'd0;
                    rbsy_r  <= 1'b0;
                    rval_r  <= 1'b0;
                    rdat_r  <= 16'h0000;
                    rdone_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.CSRAN = ~cnt_r;
    assign bus.RBSY  = rbsy_r;
    assign bus.RVAL  = rval_r;
    assign bus.RDAT  = rdat_r;
    assign bus.RDONE = rdone_r;

endmodule

// File: tb/tb_cga_mic_outcount.sv
// Self-checking bench for cga_mic_outcount: table of readback vectors with a word scoreboard,
// plus hand-written reset-state and mid-readback reset sequences.
module tb_cga_mic_outcount;

    logic MCLK = 1'b0;
    logic MRN  = 1'b0;

    always #5 MCLK = ~MCLK;

    cga_mic_outcount_if bus ();

    cga_mic_outcount dut (
        .MCLK (MCLK),
        .MRN  (MRN),
        .bus  (bus)
    );

    typedef struct {
        logic [1:0]  cd;
        logic        lrcan_n;
        logic [63:0] csd;
        int          stall;
        logic        noise;
        int          exp_n;
    } vec_t;

    typedef struct {
        logic [1:0]  csran;
        logic [15:0] rdat;
    } exp_t;

    exp_t q[$];
    vec_t vecs[6];
    int   n_cmp = 0;
    int   n_err = 0;
    int   model_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge MCLK);
        @(negedge MCLK);
    endtask

    task automatic push_words(input int start, input logic [63:0] csd);
        exp_t e;
        for (int i = start; i < 4; i++) begin
            e.csran = 2'(3 - i);
            e.rdat  = 16'(csd >> (16 * i));
            q.push_back(e);
        end
    endtask

    // Runs one readback from a negedge, checking every accepted word against the scoreboard.
    task automatic run_vec(input int id, input vec_t v);
        int   start;
        int   stall;
        int   got;
        int   dones;
        exp_t e;
        start = v.lrcan_n ? model_cnt : int'(v.cd);
        q.delete();
        push_words(start, v.csd);
        bus.CD    = v.cd;
        bus.LRCAN = v.lrcan_n;
        bus.RSTRT = 1'b1;
        bus.CSD   = v.csd;
        bus.RACK  = 1'b0;
        tick();
        bus.RSTRT = 1'b0;
        bus.LRCAN = 1'b1;
        chk($sformatf("v%0d_busy_latch", id), bus.RBSY, 1'b1);
        chk($sformatf("v%0d_rval_latch", id), bus.RVAL, 1'b0);
        tick();
        stall = v.stall;
        got   = 0;
        dones = 0;
        for (int c = 0; c < 40 && dones == 0; c++) begin
            if (bus.RDONE) begin
                dones++;
                bus.RSTRT = 1'b0;
                bus.LRCAN = 1'b1;
                bus.RACK  = 1'b0;
            end else begin
                if (bus.RVAL) begin
                    if (v.noise) begin
                        bus.RSTRT = 1'b1;
                        bus.LRCAN = 1'b0;
                        bus.CD    = 2'd0;
                    end
                    bus.CSD = {$urandom, $urandom};
                    if (stall > 0) begin
                        stall--;
                        bus.RACK = 1'b0;
                        if (q.size() > 0) begin
                            chk($sformatf("v%0d_stall_rdat", id), bus.RDAT, q[0].rdat);
                            chk($sformatf("v%0d_stall_csran", id), bus.CSRAN, q[0].csran);
                        end
                    end else begin
                        bus.RACK = 1'b1;
                        if (q.size() > 0) begin
                            e = q.pop_front();
                            chk($sformatf("v%0d_w%0d_rdat", id, got), bus.RDAT, e.rdat);
                            chk($sformatf("v%0d_w%0d_csran", id, got), bus.CSRAN, e.csran);
                        end
                        got++;
                    end
                end else begin
                    bus.RACK = 1'b0;
                    chk($sformatf("v%0d_rdat_idle", id), bus.RDAT, 16'h0000);
                end
                tick();
            end
        end
        chk($sformatf("v%0d_rdone_seen", id), dones, 1);
        chk($sformatf("v%0d_nwords", id), got, v.exp_n);
        chk($sformatf("v%0d_rval_done", id), bus.RVAL, 1'b0);
        chk($sformatf("v%0d_busy_done", id), bus.RBSY, 1'b1);
        tick();
        chk($sformatf("v%0d_rdone_once", id), bus.RDONE, 1'b0);
        chk($sformatf("v%0d_busy_idle", id), bus.RBSY, 1'b0);
        chk($sformatf("v%0d_cnt_end", id), bus.CSRAN, 2'b11);
        model_cnt = 0;
    endtask

    initial begin
        exp_t e;
        bus.CD    = 2'd0;
        bus.LRCAN = 1'b1;
        bus.RSTRT = 1'b0;
        bus.RACK  = 1'b0;
        bus.CSD   = 64'd0;

        vecs[0] = '{cd: 2'd0, lrcan_n: 1'b1, csd: 64'h4444_3333_2222_1111, stall: 0, noise: 1'b0, exp_n: 4};
        vecs[1] = '{cd: 2'd2, lrcan_n: 1'b0, csd: 64'h4444_3333_2222_1111, stall: 0, noise: 1'b0, exp_n: 2};
        vecs[2] = '{cd: 2'd3, lrcan_n: 1'b0, csd: 64'h4444_3333_2222_1111, stall: 0, noise: 1'b1, exp_n: 1};
        vecs[3] = '{cd: 2'd1, lrcan_n: 1'b0, csd: 64'hDEAD_BEEF_CAFE_F00D, stall: 2, noise: 1'b1, exp_n: 3};
        vecs[4] = '{cd: 2'd2, lrcan_n: 1'b1, csd: 64'h0123_4567_89AB_CDEF, stall: 0, noise: 1'b0, exp_n: 4};
        vecs[5] = '{cd: 2'd0, lrcan_n: 1'b1, csd: 64'hA5A5_5A5A_FFFF_0000, stall: 5, noise: 1'b0, exp_n: 4};

        @(negedge MCLK);
        chk("rst_csran", bus.CSRAN, 2'b11);
        chk("rst_rbsy",  bus.RBSY,  1'b0);
        chk("rst_rval",  bus.RVAL,  1'b0);
        chk("rst_rdat",  bus.RDAT,  16'h0000);
        chk("rst_rdone", bus.RDONE, 1'b0);
        MRN = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            run_vec(i, vecs[i]);
            tick();
        end

        // Reset after the second accepted word: immediate clear, no RDONE, clean restart.
        q.delete();
        push_words(0, 64'h4444_3333_2222_1111);
        bus.CSD   = 64'h4444_3333_2222_1111;
        bus.RSTRT = 1'b1;
        tick();
        bus.RSTRT = 1'b0;
        tick();
        for (int k = 0; k < 2; k++) begin
            bus.RACK = 1'b1;
            e = q.pop_front();
            chk($sformatf("rstmid_w%0d_rdat", k), bus.RDAT, e.rdat);
            chk($sformatf("rstmid_w%0d_csran", k), bus.CSRAN, e.csran);
            tick();
        end
        bus.RACK = 1'b0;
        chk("rstmid_before_rval", bus.RVAL, 1'b1);
        #2;
        MRN = 1'b0;
        #1;
        chk("rstmid_csran", bus.CSRAN, 2'b11);
        chk("rstmid_rbsy",  bus.RBSY,  1'b0);
        chk("rstmid_rval",  bus.RVAL,  1'b0);
        chk("rstmid_rdat",  bus.RDAT,  16'h0000);
        chk("rstmid_rdone", bus.RDONE, 1'b0);
        q.delete();
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("rstmid_nodone%0d", k), bus.RDONE, 1'b0);
        end
        MRN = 1'b1;
        model_cnt = 0;
        run_vec(10, vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
